// File: rtl/baccarat_pkg.sv
// Shared types and helpers for the baccarat hand sequencer.
// State encoding, card-rank constants and the third-card drawing rule.
package baccarat_pkg;

    typedef enum logic [3:0] {
        DEAL_P1 = 4'd0,
        DEAL_D1 = 4'd1,
        DEAL_P2 = 4'd2,
        DEAL_D2 = 4'd3,
        EVAL_P  = 4'd4,
        DEAL_P3 = 4'd5,
        EVAL_D  = 4'd6,
        DEAL_D3 = 4'd7,
        DONE    = 4'd8,
        PAUSE   = 4'd9
    } state_e;

    localparam logic [3:0] RANK_EMPTY = 4'd0;
    localparam logic [3:0] RANK_TEN   = 4'd10;
    localparam logic [3:0] NATURAL    = 4'd8;

    // Tens, faces and out-of-range ranks count zero.
    function automatic logic [3:0] card_value(input logic [3:0] rank);
        return (rank < RANK_TEN) ? rank : RANK_EMPTY;
    endfunction

    function automatic logic dealer_draws(input logic [3:0] d,
                                          input logic [3:0] v);
        logic draw;
        case (d)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:    draw = (v != 4'd8);
            4'd4:    draw = (v >= 4'd2) && (v <= 4'd7);
            4'd5:    draw = (v >= 4'd4) && (v <= 4'd7);
            4'd6:    draw = (v == 4'd6) || (v == 4'd7);
            default: draw = 1'b0;
        endcase
        return draw;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

endpackage

// File: rtl/baccarat_sequencer_if.sv
// Card datapath <-> sequencer bundle: scores in, load strobes and
// result lights out of the sequencer.
interface baccarat_sequencer_if;

    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [3:0] pcard3;
    logic       load_pcard1;
    logic       load_pcard2;
    logic       load_pcard3;
    logic       load_dcard1;
    logic       load_dcard2;
    logic       load_dcard3;
    logic       player_win_light;
    logic       dealer_win_light;
    logic       hand_done;

    modport master (
        input  pscore, dscore, pcard3,
        output load_pcard1, load_pcard2, load_pcard3,
        output load_dcard1, load_dcard2, load_dcard3,
        output player_win_light, dealer_win_light, hand_done
    );

    modport slave (
        output pscore, dscore, pcard3,
        input  load_pcard1, load_pcard2, load_pcard3,
        input  load_dcard1, load_dcard2, load_dcard3,
        input  player_win_light, dealer_win_light, hand_done
    );

endinterface

// File: rtl/baccarat_sequencer_pause_timer.sv
// 4-bit load / count-down timer; expired while the count sits at zero.
// Loaded with length-1 so the pause lasts exactly the requested cycles.
module pause_timer (
    input  logic       clk,
    input  logic       resetb,
    input  logic       load_i,
    input  logic [3:0] val_i,
    input  logic       dec_i,
    output logic       expired_o
);

    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!resetb) cnt_q <= 4'd0;
        else         cnt_q <= cnt_d;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)                       cnt_d = val_i;
        else if (dec_i && cnt_q != 4'd0)  cnt_d = cnt_q - 4'd1;
    end

    assign expired_o = (cnt_q == 4'd0);

endmodule

// File: rtl/baccarat_sequencer.sv
// Moore sequencer for one baccarat hand: deal strobes, third-card rules,
// win lights. Define BACCARAT_TALLY_EN for saturating win/tie tallies.
module baccarat_sequencer
    import baccarat_pkg::*;
#(
    parameter int PAUSE_CYCLES = 0
) (
    input  logic       slow_clock,
    input  logic       resetb,
`ifdef BACCARAT_TALLY_EN
    input  logic       tally_clrb,
    output logic [7:0] player_wins,
    output logic [7:0] dealer_wins,
    output logic [7:0] ties,
`endif
    baccarat_sequencer_if.master bus
);

    localparam bit PAUSE_EN = (PAUSE_CYCLES > 0);
    localparam logic [3:0] PAUSE_LOAD =
        PAUSE_EN ? 4'(PAUSE_CYCLES - 1) : 4'd0;

    state_e state_q, state_d, ret_q, ret_d, succ;
    logic   is_deal, tmr_load, tmr_expired, enter_done;
    logic   pwin_q, pwin_d, dwin_q, dwin_d;
    logic   resample_q, resample_d;

    pause_timer u_pause (
        .clk       (slow_clock),
        .resetb    (resetb),
        .load_i    (tmr_load),
        .val_i     (PAUSE_LOAD),
        .dec_i     (state_q == PAUSE),
        .expired_o (tmr_expired)
    );

    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            state_q    <= DEAL_P1;
            ret_q      <= DEAL_P1;
            pwin_q     <= 1'b0;
            dwin_q     <= 1'b0;
            resample_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            pwin_q     <= pwin_d;
            dwin_q     <= dwin_d;
            resample_q <= resample_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        succ     = DEAL_P1;
        is_deal  = 1'b0;
        tmr_load = 1'b0;
        unique case (state_q)
            DEAL_P1: begin is_deal = 1'b1; succ = DEAL_D1; end
            DEAL_D1: begin is_deal = 1'b1; succ = DEAL_P2; end
            DEAL_P2: begin is_deal = 1'b1; succ = DEAL_D2; end
            DEAL_D2: begin is_deal = 1'b1; succ = EVAL_P;  end
            DEAL_P3: begin is_deal = 1'b1; succ = EVAL_D;  end
            DEAL_D3: begin is_deal = 1'b1; succ = DONE;    end
            EVAL_P: begin
                if (bus.pscore >= NATURAL || bus.dscore >= NATURAL)
                    state_d = DONE;
                else if (bus.pscore <= 4'd5)
                    state_d = DEAL_P3;
                else if (bus.dscore <= 4'd5)
                    state_d = DEAL_D3;
                else
                    state_d = DONE;
            end
            EVAL_D: begin
                state_d = dealer_draws(bus.dscore, card_value(bus.pcard3))
                        ? DEAL_D3 : DONE;
            end
            DONE:    state_d = DONE;
            PAUSE:   if (tmr_expired) state_d = ret_q;
            default: state_d = DEAL_P1;
        endcase
        if (is_deal) begin
            if (PAUSE_EN) begin
                state_d  = PAUSE;
                ret_d    = succ;
                tmr_load = 1'b1;
            end else begin
                state_d  = succ;
            end
        end

        // Lights latch on DONE entry; a direct D3 entry samples once more.
        enter_done = (state_d == DONE) && (state_q != DONE);
        pwin_d     = pwin_q;
        dwin_d     = dwin_q;
        if (enter_done || resample_q) begin
            pwin_d = (bus.pscore >= bus.dscore);
            dwin_d = (bus.dscore >= bus.pscore);
        end
        resample_d = enter_done && (state_q == DEAL_D3);
    end

    always_comb begin
        bus.load_pcard1      = (state_q == DEAL_P1);
        bus.load_dcard1      = (state_q == DEAL_D1);
        bus.load_pcard2      = (state_q == DEAL_P2);
        bus.load_dcard2      = (state_q == DEAL_D2);
        bus.load_pcard3      = (state_q == DEAL_P3);
        bus.load_dcard3      = (state_q == DEAL_D3);
        bus.hand_done        = (state_q == DONE);
        bus.player_win_light = pwin_q;
        bus.dealer_win_light = dwin_q;
    end

`ifdef BACCARAT_TALLY_EN
    // Tallies survive resetb so they can span many hands.
    always_ff @(posedge slow_clock) begin
        if (!tally_clrb) begin
            player_wins <= 8'd0;
            dealer_wins <= 8'd0;
            ties        <= 8'd0;
        end else if (resetb && enter_done) begin
            if (pwin_d && !dwin_d)
                player_wins <= sat_inc(player_wins);
            else if (dwin_d && !pwin_d)
                dealer_wins <= sat_inc(dealer_wins);
            else
                ties <= sat_inc(ties);
        end
    end
`endif

endmodule

// File: tb/tb_baccarat_sequencer.sv
// Bench: two sequencers (no pause, 3-cycle pause) against a hand-level
// model of the deal trace built from the baccarat rules.
module tb_baccarat_sequencer;

    logic clk    = 1'b0;
    logic resetb = 1'b0;
    always #5 clk = ~clk;

`ifdef BACCARAT_TALLY_EN
    logic       tally_clrb = 1'b1;
    logic [7:0] pw0, dw0, tw0, pw3, dw3, tw3;
`endif

    baccarat_sequencer_if bus0 ();
    baccarat_sequencer_if bus3 ();

    baccarat_sequencer #(.PAUSE_CYCLES(0)) dut0 (
        .slow_clock  (clk),
        .resetb      (resetb),
`ifdef BACCARAT_TALLY_EN
        .tally_clrb  (tally_clrb),
        .player_wins (pw0),
        .dealer_wins (dw0),
        .ties        (tw0),
`endif
        .bus         (bus0)
    );

    baccarat_sequencer #(.PAUSE_CYCLES(3)) dut3 (
        .slow_clock  (clk),
        .resetb      (resetb),
`ifdef BACCARAT_TALLY_EN
        .tally_clrb  (tally_clrb),
        .player_wins (pw3),
        .dealer_wins (dw3),
        .ties        (tw3),
`endif
        .bus         (bus3)
    );

    int         rank [6];
    logic [3:0] c0 [6];
    logic [3:0] c3 [6];
    logic [5:0] s0, s3;
    logic [8:0] tr [2][64];
    int         tlen [2];
    logic [8:0] done_v [2];
    int         cnt [2][6];
    int         total = 0;
    int         bad   = 0;

    function automatic int val(input int r);
        return (r >= 1 && r <= 9) ? r : 0;
    endfunction

    function automatic bit dr(input int d, input int v);
        case (d)
            0, 1, 2: return 1'b1;
            3:       return v != 8;
            4:       return v inside {[2:7]};
            5:       return v inside {[4:7]};
            6:       return v inside {6, 7};
            default: return 1'b0;
        endcase
    endfunction

    assign s0 = {bus0.load_dcard3, bus0.load_pcard3, bus0.load_dcard2,
                 bus0.load_pcard2, bus0.load_dcard1, bus0.load_pcard1};
    assign s3 = {bus3.load_dcard3, bus3.load_pcard3, bus3.load_dcard2,
                 bus3.load_pcard2, bus3.load_dcard1, bus3.load_pcard1};

    always_comb begin
        bus0.pscore = 4'((val(c0[0]) + val(c0[2]) + val(c0[4])) % 10);
        bus0.dscore = 4'((val(c0[1]) + val(c0[3]) + val(c0[5])) % 10);
        bus0.pcard3 = c0[4];
        bus3.pscore = 4'((val(c3[0]) + val(c3[2]) + val(c3[4])) % 10);
        bus3.dscore = 4'((val(c3[1]) + val(c3[3]) + val(c3[5])) % 10);
        bus3.pcard3 = c3[4];
    end

    // Datapath model: card registers capture on the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 6; i++) begin
            if (!resetb) begin
                c0[i] <= 4'd0;
                c3[i] <= 4'd0;
            end else begin
                if (s0[i]) c0[i] <= 4'(rank[i]);
                if (s3[i]) c3[i] <= 4'(rank[i]);
            end
        end
    end

    task automatic push(input int u, input int n, input int bitno);
        tr[u][tlen[u]] = 9'(1 << bitno);
        tlen[u]++;
        for (int j = 0; j < n; j++) begin
            tr[u][tlen[u]] = 9'd0;
            tlen[u]++;
        end
    endtask

    task automatic build(input int u, input int n);
        int p, d, v;
        tlen[u] = 0;
        for (int i = 0; i < 4; i++) push(u, n, i);
        tr[u][tlen[u]] = 9'd0;
        tlen[u]++;
        p = (val(rank[0]) + val(rank[2])) % 10;
        d = (val(rank[1]) + val(rank[3])) % 10;
        if (p < 8 && d < 8) begin
            if (p <= 5) begin
                push(u, n, 4);
                tr[u][tlen[u]] = 9'd0;
                tlen[u]++;
                v = val(rank[4]);
                p = (p + v) % 10;
                if (dr(d, v)) begin
                    push(u, n, 5);
                    d = (d + val(rank[5])) % 10;
                end
            end else if (d <= 5) begin
                push(u, n, 5);
                d = (d + val(rank[5])) % 10;
            end
        end
        done_v[u] = {1'b1, p >= d, d >= p, 6'd0};
    endtask

    task automatic set_hand(input int a, input int b, input int c,
                            input int d, input int e, input int f);
        rank[0] = a; rank[1] = b; rank[2] = c;
        rank[3] = d; rank[4] = e; rank[5] = f;
        build(0, 0);
        build(1, 3);
    endtask

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int n);
        resetb = 1'b0;
        run(n);
        resetb = 1'b1;
    endtask

    task automatic play(input int mid);
        do_reset(2);
        if (mid > 0) begin
            run(mid);
            do_reset(1);
        end
        run(tlen[1] + 3);
    endtask

    initial begin : cmp
        int         k;
        bit         started;
        logic       r;
        logic [8:0] act, exp;
        k = 0;
        started = 1'b0;
        forever begin
            @(posedge clk);
            r = resetb;
            #1;
            if (!r) begin
                k = 0;
                started = 1'b1;
                for (int u = 0; u < 2; u++)
                    for (int i = 0; i < 6; i++) cnt[u][i] = 0;
            end else if (started) begin
                k++;
            end
            if (started) begin
                for (int u = 0; u < 2; u++) begin
                    if (u == 0)
                        act = {bus0.hand_done, bus0.player_win_light,
                               bus0.dealer_win_light, s0};
                    else
                        act = {bus3.hand_done, bus3.player_win_light,
                               bus3.dealer_win_light, s3};
                    exp = (k < tlen[u]) ? tr[u][k] : done_v[u];
                    for (int i = 0; i < 6; i++) cnt[u][i] += int'(act[i]);
                    total++;
                    if (act !== exp) begin
                        bad++;
                        $display("FAIL cycle u=%0d k=%0d got=%b want=%b",
                                 u, k, act, exp);
                    end
                end
            end
        end
    end

    initial begin
        // Natural: player 8, dealer 3.
        set_hand(3, 1, 5, 2, 4, 4);
        chk("model_nat_len0", tlen[0], 5);
        chk("model_nat_len3", tlen[1], 17);
        chk("model_nat_done", int'(done_v[0]), 'h180);
        play(0);
        chk("nat_p3", cnt[0][4], 0);
        chk("nat_d3", cnt[0][5], 0);
        chk("nat_lights",
            int'({bus0.player_win_light, bus0.dealer_win_light}), 2);
        chk("nat_done3", int'(bus3.hand_done), 1);

        // Player 4 draws a 5, dealer 7 stands.
        set_hand(2, 3, 2, 4, 5, 6);
        chk("model_pd_len", tlen[0], 7);
        chk("model_pd_done", int'(done_v[0]), 'h180);
        play(0);
        chk("pd_deals", cnt[0][0] + cnt[0][1] + cnt[0][2] + cnt[0][3], 4);
        chk("pd_p3", cnt[0][4], 1);
        chk("pd_d3", cnt[0][5], 0);
        chk("pd_p3_pause", cnt[1][4], 1);

        // Dealer 6 draws on player third card 7.
        set_hand(1, 3, 1, 3, 7, 2);
        play(0);
        chk("dc7_d3", cnt[0][5], 1);
        chk("dc7_lights",
            int'({bus0.player_win_light, bus0.dealer_win_light}), 2);

        // Same with a queen: value 0, dealer 6 stands.
        set_hand(1, 3, 1, 3, 12, 2);
        chk("model_dq_done", int'(done_v[0]), 'h140);
        play(0);
        chk("dq_d3", cnt[0][5], 0);
        chk("dq_lights",
            int'({bus0.player_win_light, bus0.dealer_win_light}), 1);

        // Player 6 stands, dealer 5 draws to a 6/6 tie.
        set_hand(3, 2, 3, 3, 9, 1);
        chk("model_tie_len", tlen[0], 6);
        chk("model_tie_done", int'(done_v[0]), 'h1C0);
        play(0);
        chk("tie_p3", cnt[0][4], 0);
        chk("tie_d3", cnt[0][5], 1);
        chk("tie_lights0",
            int'({bus0.player_win_light, bus0.dealer_win_light}), 3);
        chk("tie_lights3",
            int'({bus3.player_win_light, bus3.dealer_win_light}), 3);

        // Reset during the pause that follows the second player card.
        set_hand(2, 3, 2, 4, 5, 6);
        do_reset(2);
        run(10);
        resetb = 1'b0;
        run(1);
        chk("mid_p1", int'(bus3.load_pcard1), 1);
        chk("mid_strobes", int'(s3), 1);
        chk("mid_lights",
            int'({bus3.player_win_light, bus3.dealer_win_light,
                  bus3.hand_done}), 0);
        resetb = 1'b1;
        run(tlen[1] + 3);
        chk("mid_final",
            int'({bus3.player_win_light, bus3.dealer_win_light}), 2);

        for (int h = 0; h < 40; h++) begin
            int mid;
            set_hand($urandom_range(1, 13), $urandom_range(1, 13),
                     $urandom_range(1, 13), $urandom_range(1, 13),
                     $urandom_range(1, 13), $urandom_range(1, 13));
            mid = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
            play(mid);
        end

`ifdef BACCARAT_TALLY_EN
        tally_clrb = 1'b0;
        run(1);
        tally_clrb = 1'b1;
        set_hand(3, 1, 5, 2, 4, 4);
        play(0);
        set_hand(1, 3, 1, 3, 12, 2);
        play(4);
        set_hand(3, 2, 3, 3, 9, 1);
        play(0);
        chk("tally_p0", int'(pw0), 1);
        chk("tally_d0", int'(dw0), 1);
        chk("tally_t0", int'(tw0), 1);
        chk("tally_p3", int'(pw3), 1);
        chk("tally_d3", int'(dw3), 1);
        chk("tally_t3", int'(tw3), 1);
        tally_clrb = 1'b0;
        run(1);
        tally_clrb = 1'b1;
        chk("tally_clr", int'(pw0) + int'(dw0) + int'(tw0)
                         + int'(pw3) + int'(dw3) + int'(tw3), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
